// File: rtl/shift_right20.sv
// Registered right shifter: SHW-stage logarithmic shifter followed by one output register.
// ARITH selects zero fill (0) or sign fill from the original operand MSB (1).
module shift_right20 #(
  parameter int WIDTH = 20,
  parameter int SHW   = 4,
  parameter int ARITH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   b,
  output logic [WIDTH-1:0] c
);

  logic             w_fill;
  logic [WIDTH-1:0] w_stage [SHW+1];
  logic [WIDTH-1:0] r_c;

  // Fill always comes from the unshifted operand, not from any intermediate stage.
  assign w_fill     = (ARITH != 0) ? a[WIDTH-1] : 1'b0;
  assign w_stage[0] = a;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int SH = 1 << k;
    if (SH >= WIDTH) begin : g_full
      assign w_stage[k+1] = b[k] ? {WIDTH{w_fill}} : w_stage[k];
    end else begin : g_part
      assign w_stage[k+1] = b[k] ? {{SH{w_fill}}, w_stage[k][WIDTH-1:SH]} : w_stage[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c <= '0;
    end else begin
      r_c <= w_stage[SHW];
    end
  end

  assign c = r_c;

endmodule

// File: tb/tb_shift_right20.sv
// Bench for shift_right20: directed vector table, hand sequences, then randomized
// traffic against an arithmetic reference, on both logical and arithmetic variants.
module tb_shift_right20;

  localparam int WIDTH = 20;
  localparam int SHW   = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   b;
  logic [WIDTH-1:0] c_log;
  logic [WIDTH-1:0] c_ari;

  int n_total;
  int n_pass;

  shift_right20 #(.WIDTH(WIDTH), .SHW(SHW), .ARITH(0)) u_log (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c_log)
  );

  shift_right20 #(.WIDTH(WIDTH), .SHW(SHW), .ARITH(1)) u_ari (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c_ari)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   b;
    logic [WIDTH-1:0] exp_log;
    logic [WIDTH-1:0] exp_ari;
    string            name;
  } vec_t;

  vec_t vecs [$];

  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] x,
                                                 input int unsigned sh,
                                                 input bit arith);
    logic signed [WIDTH-1:0] sx;
    if (arith) begin
      sx = x;
      return sx >>> sh;
    end
    return x >> sh;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled likewise.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [WIDTH-1:0] av, input logic [SHW-1:0] bv,
                     input logic [WIDTH-1:0] el, input logic [WIDTH-1:0] ea, input string nm);
    vec_t v;
    v.rst = r; v.a = av; v.b = bv; v.exp_log = el; v.exp_ari = ea; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    a   = '0;
    b   = '0;

    add(1'b1, 20'hFFFFF, 4'd3,  20'h00000, 20'h00000, "reset_edge1");
    add(1'b1, 20'hFFFFF, 4'd3,  20'h00000, 20'h00000, "reset_edge2");
    add(1'b0, 20'hFFFFF, 4'd3,  20'h1FFFF, 20'hFFFFF, "first_after_reset");
    add(1'b0, 20'h12345, 4'd0,  20'h12345, 20'h12345, "b0_passthrough");
    add(1'b0, 20'h80000, 4'd4,  20'h08000, 20'hF8000, "msb_by4");
    add(1'b0, 20'hFFFFF, 4'd15, 20'h0001F, 20'hFFFFF, "max_shift_ones");
    add(1'b0, 20'hA5A5A, 4'd15, 20'h00014, 20'hFFFF4, "max_shift_pattern");
    add(1'b0, 20'h7FFFF, 4'd15, 20'h0000F, 20'h0000F, "max_shift_pos");
    add(1'b0, 20'hF0000, 4'd1,  20'h78000, 20'hF8000, "b2b_1");
    add(1'b0, 20'hF0000, 4'd2,  20'h3C000, 20'hFC000, "b2b_2");
    add(1'b0, 20'hF0000, 4'd4,  20'h0F000, 20'hFF000, "b2b_4");
    add(1'b0, 20'hF0000, 4'd8,  20'h00F00, 20'hFFF00, "b2b_8");
    add(1'b0, 20'hAAAAA, 4'd2,  20'h2AAAA, 20'hEAAAA, "stream_pre");
    add(1'b1, 20'hAAAAA, 4'd2,  20'h00000, 20'h00000, "stream_rst");
    add(1'b0, 20'hAAAAA, 4'd2,  20'h2AAAA, 20'hEAAAA, "stream_post");
    add(1'b0, 20'h0000A, 4'd1,  20'h00005, 20'h00005, "small_by1");

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      a   = vecs[i].a;
      b   = vecs[i].b;
      step();
      check({vecs[i].name, "_log"}, c_log, vecs[i].exp_log);
      check({vecs[i].name, "_ari"}, c_ari, vecs[i].exp_ari);
    end

    // One-cycle latency: the output must not follow a new input before the edge.
    rst = 1'b0; a = 20'h0000A; b = 4'd1;
    step();
    a = 20'h12345; b = 4'd0;
    #2;
    check("latency_hold", c_log, 20'h00005);
    $display("a=0x%05h b=%0d c=0x%05h", 20'h0000A, 1, c_log);
    step();
    check("latency_update", c_log, 20'h12345);

    // Reset held over several cycles with changing data, then released.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = WIDTH'($urandom); b = SHW'($urandom);
      step();
      check("held_reset_log", c_log, '0);
      check("held_reset_ari", c_ari, '0);
    end
    rst = 1'b0; a = 20'h80001; b = 4'd3;
    step();
    check("release_log", c_log, 20'h10000);
    check("release_ari", c_ari, 20'hF0000);

    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] ra;
      logic [SHW-1:0]   rb;
      logic             rr;
      ra = WIDTH'($urandom);
      rb = SHW'($urandom);
      rr = ($urandom_range(0, 19) == 0);
      rst = rr; a = ra; b = rb;
      step();
      check("rand_log", c_log, rr ? '0 : ref_shift(ra, rb, 1'b0));
      check("rand_ari", c_ari, rr ? '0 : ref_shift(ra, rb, 1'b1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
